// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register for the RV32I core.
// It replaces the fixed ID/EX latch and fits any stage boundary (IF/ID,
// ID/EX, EX/MEM, ...).
//
// Features:
//   - valid/ready handshake on both sides.
//   - Synchronous flush, used to kill wrong-path entries after a branch
//     mispredict.
//   - Optional second storage entry (skid buffer), so in_ready comes from
//     registers and does not depend combinationally on out_ready.
//   - A bubble never drives a register write downstream.
//
// Parameters:
//   PAYLOAD_W  width of the opaque stage payload
//   DEPTH      1 = single register, in_ready passes out_ready through
//              2 = skid buffer, in_ready is registered
//              (other values are not supported)
//   CNT_W      width of the statistics counters
//
// Ports:
//   clk, rst (async, active-low), en (stage enable), flush
//   in_valid / in_ready / in_data / in_rd / in_reg_write_en      upstream side
//   out_valid / out_ready / out_data / out_rd / out_reg_write_en downstream side
//   occupancy  number of valid entries held
//
// Optional build macro PIPE_STAT_EN adds two saturating counters:
//   stall_cnt  cycles where the head entry is held by back-pressure
//   flush_cnt  flushes that killed at least one entry
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 160,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic [4:0]           in_rd,
  input  logic                 in_reg_write_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [4:0]           out_rd,
  output logic                 out_reg_write_en,
  output logic [1:0]           occupancy
`ifdef PIPE_STAT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
`endif
);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] data;
    logic [4:0]           rd;
    logic                 we;
  } entry_t;

  entry_t     in_entry;
  entry_t     slot0_p1;   // head
  entry_t     slot1_p1;   // tail, used only when two entries are held
  entry_t     slot0_nxt;
  entry_t     slot1_nxt;
  logic [1:0] occ_p1;
  logic [1:0] occ_nxt;
  logic       push;
  logic       pop;

  assign in_entry = '{data: in_data, rd: in_rd, we: in_reg_write_en};

  // Handshake, combinational from held state
  assign out_valid = en & (occ_p1 != 2'd0);

  generate
    if (DEPTH == 1) begin : g_ready_pass
      // The single slot can refill in the same cycle it drains.
      assign in_ready = en & ((occ_p1 == 2'd0) | out_ready);
    end else begin : g_ready_skid
      // Registered state only; the spare slot absorbs a late out_ready drop.
      assign in_ready = en & (occ_p1 < 2'd2);
    end
  endgenerate

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign out_data         = slot0_p1.data;
  assign out_rd           = slot0_p1.rd;
  assign out_reg_write_en = out_valid & slot0_p1.we;
  assign occupancy        = occ_p1;

  always_comb begin
    slot0_nxt = slot0_p1;
    slot1_nxt = slot1_p1;
    occ_nxt   = occ_p1;
    if (en) begin
      if (flush) begin
        // A same-cycle pop has already been sampled downstream. A
        // same-cycle push is dropped.
        occ_nxt   = 2'd0;
        slot0_nxt = '0;
        slot1_nxt = '0;
      end else if (push && !pop) begin
        if (occ_p1 == 2'd0) begin
          slot0_nxt = in_entry;
        end else begin
          slot1_nxt = in_entry;
        end
        occ_nxt = occ_p1 + 2'd1;
      end else if (pop && !push) begin
        slot0_nxt = slot1_p1;
        slot1_nxt = '0;
        occ_nxt   = occ_p1 - 2'd1;
      end else if (push && pop) begin
        if (occ_p1 == 2'd1) begin
          // The old head leaves, so the new entry becomes the head.
          slot0_nxt = in_entry;
        end else begin
          slot0_nxt = slot1_p1;
          slot1_nxt = in_entry;
        end
      end
    end
  end

  // Stage register: entry storage and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0_p1 <= '0;
      slot1_p1 <= '0;
      occ_p1   <= 2'd0;
    end else begin
      slot0_p1 <= slot0_nxt;
      slot1_p1 <= slot1_nxt;
      occ_p1   <= occ_nxt;
    end
  end

`ifdef PIPE_STAT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Statistics counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (en && out_valid && !out_ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (en && flush && (occ_p1 != 2'd0)) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed testbench for pipe_stage_reg with the default
// parameters (DEPTH=2). It also covers the statistics counters when
// PIPE_STAT_EN is defined.
module tb_pipe_stage_reg;

  localparam int PW = 160;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic [4:0]    in_rd;
  logic          in_reg_write_en;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic [4:0]    out_rd;
  logic          out_reg_write_en;
  logic [1:0]    occupancy;
`ifdef PIPE_STAT_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_reg #(.PAYLOAD_W(PW), .DEPTH(2), .CNT_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_rd            (in_rd),
    .in_reg_write_en  (in_reg_write_en),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_rd           (out_rd),
    .out_reg_write_en (out_reg_write_en),
    .occupancy        (occupancy)
`ifdef PIPE_STAT_EN
    ,
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [4:0] rd, input logic we);
    in_valid        = v;
    in_data         = {128'h0, inst};
    in_rd           = rd;
    in_reg_write_en = we;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_occ"}, occupancy, 2'd0);
    chk({tag, "_vld"}, out_valid, 1'b0);
    chk({tag, "_data"}, out_data, {PW{1'b0}});
    chk({tag, "_rd"}, out_rd, 5'd0);
    chk({tag, "_we"}, out_reg_write_en, 1'b0);
  endtask

  initial begin
    logic [165:0] q[$];
    logic [31:0]  seq;
    int           pops;
    int           cyc;

    rst       = 1'b0;
    en        = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);

    // Reset held while the inputs toggle randomly.
    repeat (4) begin
      tick();
      en        = 1'($urandom_range(0, 1));
      flush     = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 1'b1);
      #1;
      chk_zero("rst_hold");
    end
    tick();
    rst       = 1'b1;
    en        = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 1'b0);

    // Single entry passes through with one-cycle latency.
    drive(1'b1, 32'h00200513, 5'd10, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    #1;
    chk("sp_vld", out_valid, 1'b1);
    chk("sp_rd", out_rd, 5'd10);
    chk("sp_we", out_reg_write_en, 1'b1);
    chk("sp_data", out_data, {128'h0, 32'h00200513});
    chk("sp_occ1", occupancy, 2'd1);
    tick();
    #1;
    chk("sp_occ0", occupancy, 2'd0);
    chk("sp_we0", out_reg_write_en, 1'b0);

    // Back-pressure fills the stage, and a third entry is refused.
    out_ready = 1'b0;
    drive(1'b1, 32'h00000013, 5'd1, 1'b1);
    tick();
    drive(1'b1, 32'h00200593, 5'd11, 1'b1);
    tick();
    #1;
    chk("bp_occ2", occupancy, 2'd2);
    chk("bp_rdy0", in_ready, 1'b0);
    drive(1'b1, 32'hdeadbeef, 5'd12, 1'b1);
    tick();
    #1;
    chk("bp_hold_occ", occupancy, 2'd2);
    chk("bp_hold_head", out_data, {128'h0, 32'h00000013});
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_out0_vld", out_valid, 1'b1);
    chk("bp_out0", out_data, {128'h0, 32'h00000013});
    tick();
    #1;
    chk("bp_out1", out_data, {128'h0, 32'h00200593});
    chk("bp_out1_rd", out_rd, 5'd11);
    tick();
    #1;
    chk("bp_drained", occupancy, 2'd0);

    // Push and pop together with one entry held.
    out_ready = 1'b0;
    drive(1'b1, 32'h000000e1, 5'd3, 1'b0);
    tick();
    drive(1'b1, 32'h000000f1, 5'd4, 1'b1);
    out_ready = 1'b1;
    #1;
    chk("pp_pre_occ", occupancy, 2'd1);
    chk("pp_pre_head", out_data, {128'h0, 32'h000000e1});
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    #1;
    chk("pp_occ", occupancy, 2'd1);
    chk("pp_head", out_data, {128'h0, 32'h000000f1});
    chk("pp_we", out_reg_write_en, 1'b1);
    tick();
    #1;
    chk("pp_drained", occupancy, 2'd0);

    // Random back-pressure stream compared against a FIFO model.
    seq  = 32'h1000;
    pops = 0;
    cyc  = 0;
    while (pops < 100 && cyc < 2000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 3) != 0), seq, seq[4:0], seq[0]);
      #1;
      chk("sb_occ", occupancy, q.size());
      chk("sb_rdy", in_ready, (q.size() < 2));
      chk("sb_vld", out_valid, (q.size() != 0));
      if (out_valid && out_ready && q.size() != 0) begin
        chk("sb_head", {out_data, out_rd, out_reg_write_en}, q.pop_front());
        pops++;
      end
      if (in_valid && in_ready) begin
        q.push_back({in_data, in_rd, in_reg_write_en});
        seq = seq + 32'd1;
      end
      tick();
      cyc++;
    end
    chk("sb_done", pops, 100);
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("sb_empty", occupancy, 2'd0);
    q.delete();

    // Flush with a full stage and a same-cycle push.
    out_ready = 1'b0;
    drive(1'b1, 32'h00000a01, 5'd5, 1'b1);
    tick();
    drive(1'b1, 32'h00000a02, 5'd6, 1'b1);
    tick();
    drive(1'b1, 32'h0badf00d, 5'd7, 1'b1);
    flush = 1'b1;
    #1;
    chk("fl_pre_occ", occupancy, 2'd2);
    tick();
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    #1;
    chk("fl_occ", occupancy, 2'd0);
    chk("fl_vld", out_valid, 1'b0);
    chk("fl_we", out_reg_write_en, 1'b0);
    repeat (3) begin
      tick();
      chk("fl_noleak", out_valid, 1'b0);
    end

    // Flush while the stage is disabled has no effect.
    out_ready = 1'b0;
    drive(1'b1, 32'h00000b01, 5'd8, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    en    = 1'b0;
    flush = 1'b1;
    tick();
    en    = 1'b1;
    flush = 1'b0;
    #1;
    chk("fl_en0_occ", occupancy, 2'd1);
    chk("fl_en0_head", out_data, {128'h0, 32'h00000b01});

    // Enable low freezes the stage even with traffic offered.
    en        = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h00000c01, 5'd9, 1'b1);
    repeat (5) begin
      tick();
      chk("frz_rdy", in_ready, 1'b0);
      chk("frz_vld", out_valid, 1'b0);
      chk("frz_occ", occupancy, 2'd1);
    end
    en = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    #1;
    chk("frz_resume_vld", out_valid, 1'b1);
    chk("frz_resume_head", out_data, {128'h0, 32'h00000b01});
    tick();
    #1;
    chk("frz_drained", occupancy, 2'd0);

    // Asynchronous reset mid-stream with two entries held.
    out_ready = 1'b0;
    drive(1'b1, 32'h00000d01, 5'd13, 1'b1);
    tick();
    drive(1'b1, 32'h00000d02, 5'd14, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    #1;
    chk("ar_pre_occ", occupancy, 2'd2);
    rst = 1'b0;
    #1;
    chk_zero("ar");
    tick();
    rst = 1'b1;

`ifdef PIPE_STAT_EN
    #1;
    chk("st_rst_stall", stall_cnt, 16'd0);
    chk("st_rst_flush", flush_cnt, 16'd0);
    drive(1'b1, 32'h00000e01, 5'd15, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    repeat (7) tick();
    chk("st_stall7", stall_cnt, 16'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b1, 32'h00000e02, 5'd16, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    flush = 1'b1;
    tick();
    // The stage is empty now, so this flush is not counted.
    tick();
    flush = 1'b0;
    #1;
    chk("st_flush2", flush_cnt, 16'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed ID/EX latch.
- A generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, ...) for the RV32I core.
- Adds a valid/ready handshake, a synchronous flush (branch mispredict), and optional 2-entry skid buffering so back-pressure does not create a combinational ready path.
- Bubbles never carry a register-write enable downstream.

Parameters:
- PAYLOAD_W, 160: width of the opaque stage payload (pc4, pc, inst, operands, control fields).
- DEPTH, 2: storage entries. 1 = plain register with combinational ready pass-through; 2 = skid buffer with registered in_ready. Other values are illegal.
- CNT_W, 16: width of the statistics counters (only used with PIPE_STAT_EN).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous reset, active-low.
- en, input, 1: stage enable; 0 freezes all state.
- flush, input, 1: synchronous kill of all held entries.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage accepts an entry this cycle.
- in_data, input, PAYLOAD_W: upstream payload.
- in_rd, input, 5: destination register index.
- in_reg_write_en, input, 1: upstream register-write request.
- out_valid, output, 1: head entry valid.
- out_ready, input, 1: downstream accepts the head entry.
- out_data, output, PAYLOAD_W: head payload.
- out_rd, output, 5: head destination register.
- out_reg_write_en, output, 1: head write request, gated by out_valid.
- occupancy, output, 2: number of valid entries (0..DEPTH).

Behaviour:
- Reset (rst=0, asynchronous): occupancy=0, out_valid=0, out_data=0, out_rd=0, out_reg_write_en=0, all entries cleared. Release is synchronous to clk.
- push = en & in_valid & in_ready; pop = en & out_valid & out_ready.
- Latency: an entry pushed at edge N appears on out_* after edge N (1 cycle) when the stage was empty.
- Ordering: strict FIFO. Head is entry 0; on pop, entry 1 shifts to entry 0.
- in_ready for DEPTH=1: en & (occupancy==0 | out_ready).
- in_ready for DEPTH=2: en & (occupancy<2). It is a registered-state function only; no path from out_ready.
- out_valid = en & (occupancy!=0). While en=0, out_valid=0 and in_ready=0, no transfers occur, and the contents are held.
- out_reg_write_en = out_valid & head.reg_write_en. out_data and out_rd show the head contents even when the entry is invalid (don't-care), but a bubble never asserts a write.
- Occupancy transitions (en=1, flush=0):
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. The new entry goes to the tail, or directly to the head if occupancy was 1.
- Full (occupancy==DEPTH, DEPTH=2): in_ready=0, so in_valid is ignored.
- Empty: out_valid=0; a pop cannot occur.
- Flush with en=1: occupancy becomes 0 at the next edge and all entries are invalidated.
  - Flush has priority over push: the same-cycle in_data is discarded.
  - A same-cycle pop still completes, since downstream sampled it.
- Flush with en=0: ignored.
- Reset asserted mid-operation: immediately forces the reset values, independent of clk and en.

Optional Feature:
- Macro: PIPE_STAT_EN.
- Defined:
  - Adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0], both reset to 0.
  - stall_cnt increments on every cycle with en & out_valid & ~out_ready.
  - flush_cnt increments on every cycle with en & flush & (occupancy!=0).
  - Both counters saturate at all-ones (no wrap).
- Not defined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, occupancy=0. Assert rst=0 mid-stream with occupancy=2 -> outputs 0 before the next clk edge.
- Single pass: DEPTH=2, en=1, out_ready=1, push inst 0x00200513 with in_rd=10 and in_reg_write_en=1 -> one cycle later out_valid=1, out_rd=10, out_reg_write_en=1. It pops the next cycle and occupancy returns to 0.
- Back-pressure: out_ready=0, push 0x00000013 then 0x00200593 -> occupancy=2 and in_ready=0; a third in_valid is ignored. Release out_ready -> outputs 0x00000013 then 0x00200593 in order on consecutive cycles.
- Simultaneous push/pop: occupancy=1, in_valid=1, out_ready=1 -> occupancy stays 1, the new entry becomes head next cycle, no loss or duplication over 100 random-back-pressure transfers checked against a scoreboard.
- Flush: occupancy=2, flush=1 together with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_reg_write_en=0, and the flushed-cycle payload never appears.
- Enable freeze plus stats (PIPE_STAT_EN): en=0 for 5 cycles with occupancy=1 -> in_ready=0, out_valid=0, contents unchanged, then resume. Hold out_ready=0 for 7 cycles with en=1 and occupancy≥1 -> stall_cnt=7. Two flushes with occupancy≥1 -> flush_cnt=2.
